ccff_loader: RTL and testbench

CCFF_LOADER -- requirements
Module: ccff_loader

---
 rtl/ccff_loader.sv | 170 +++++++++++++++++
 tb/tb_ccff_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ccff_loader.sv
// ccff_loader -- streams a configuration bitstream into a chain of
// configuration flip-flops (ccff) and then checks the load by recirculating
// the chain once.
//
// A load runs through IDLE -> LOAD -> VERIFY -> DONE. In LOAD, the loader
// takes words and shifts them MSB first into ccff_head. It holds one word at
// a time, and it truncates the final word so that exactly CHAIN_LEN bits go
// in. In VERIFY, it feeds ccff_tail back into ccff_head for CHAIN_LEN cycles.
// This leaves the chain contents where they were. The parity of the bits
// that come out is compared with the parity of the bits that went in.
//
// Ports:
//   prog_clk       programming clock (also clocks the chain)
//   prog_rst_n     asynchronous active-low reset
//   start          one-cycle pulse; starts a load from IDLE or DONE
//   cfg_data       bitstream word, shifted MSB first
//   cfg_valid      cfg_data valid
//   cfg_ready      the loader accepts cfg_data this cycle
//   ccff_head      serial data into the first chain flip-flop
//   ccff_tail      serial data out of the last chain flip-flop
//   ccff_shift_en  chain advances one bit on every edge where this is 1
//   busy           high in LOAD or VERIFY
//   done           high in DONE
//   error          verify parity mismatch; sticky until next start/reset
module ccff_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int DATA_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int          CNT_W = $clog2(DATA_W + 1);
  localparam logic [15:0] LEN   = 16'(CHAIN_LEN);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    VERIFY,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] buf_q;       // word being shifted; the bit at the MSB goes out next
  logic [CNT_W-1:0]  buf_cnt_q;   // bits in buf_q not yet shifted out
  logic [15:0]       rem_q;       // chain bits not yet shifted in
  logic [15:0]       vcnt_q;      // recirculation cycles left in VERIFY
  logic              par_load_q;
  logic              par_ver_q;
  logic              error_q;

  logic              buf_valid;
  logic              load_shift;
  logic              start_ok;
  logic              take;
  logic [15:0]       rem_after;
  logic [CNT_W-1:0]  fill_cnt;

  assign buf_valid  = (buf_cnt_q != '0);
  assign load_shift = (state_q == LOAD) && buf_valid;
  assign start_ok   = start && ((state_q == IDLE) || (state_q == DONE));
  assign rem_after  = rem_q - 16'(load_shift);

  // Ask for a new word only if the buffer will be empty after this edge and
  // the chain still needs more bits than the buffer holds. This lets a new
  // word follow the last bit of the previous one with no gap. It also stops
  // the loader from asking for a word after the final (possibly partial) one.
  assign cfg_ready = (state_q == LOAD)
                  && (!buf_valid || (buf_cnt_q == CNT_W'(1)))
                  && (rem_q > 16'(buf_cnt_q));
  assign take      = cfg_ready && cfg_valid;

  // Only the top bits of the final word are used. The low bits never reach
  // the MSB position before the bit count reaches zero.
  assign fill_cnt  = (rem_after >= 16'(DATA_W)) ? CNT_W'(DATA_W)
                                                : CNT_W'(rem_after);

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples values from before the edge, whatever the block order.
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first. A path that
  // leaves one unassigned would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    ccff_shift_en = 1'b0;
    ccff_head     = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        busy          = 1'b1;
        ccff_shift_en = buf_valid;
        ccff_head     = buf_valid & buf_q[DATA_W-1];
        if (load_shift && (rem_q == 16'd1)) state_d = VERIFY;
      end
      VERIFY: begin
        busy          = 1'b1;
        ccff_shift_en = 1'b1;
        ccff_head     = ccff_tail;
        if (vcnt_q == 16'd1) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the word buffer is an ordinary register, not a memory. It is
  // reset together with the counters, so the loader starts clean after
  // an abort.
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      buf_q      <= '0;
      buf_cnt_q  <= '0;
      rem_q      <= '0;
      vcnt_q     <= '0;
      par_load_q <= 1'b0;
      par_ver_q  <= 1'b0;
      error_q    <= 1'b0;
    end else if (start_ok) begin
      buf_cnt_q  <= '0;
      rem_q      <= LEN;
      vcnt_q     <= LEN;
      par_load_q <= 1'b0;
      par_ver_q  <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      if (state_q == LOAD) begin
        if (take) begin
          buf_q     <= cfg_data;
          buf_cnt_q <= fill_cnt;
        end else if (load_shift) begin
          buf_q     <= buf_q << 1;
          buf_cnt_q <= buf_cnt_q - CNT_W'(1);
        end
        if (load_shift) begin
          rem_q      <= rem_after;
          par_load_q <= par_load_q ^ buf_q[DATA_W-1];
        end
      end
      if (state_q == VERIFY) begin
        vcnt_q    <= vcnt_q - 16'd1;
        par_ver_q <= par_ver_q ^ ccff_tail;
        // The last tail bit is included directly, because par_ver_q does
        // not have it yet on this edge.
        if (vcnt_q == 16'd1) error_q <= par_load_q ^ par_ver_q ^ ccff_tail;
      end
    end
  end

  assign error = error_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Testbench for ccff_loader with CHAIN_LEN=10, DATA_W=8. The chain is
// modelled as a 10-bit shift register. The bits expected on ccff_head are
// queued when a load is set up, and they are popped as the DUT shifts.
module tb_ccff_loader;
  localparam int N = 10;
  localparam int W = 8;

  logic         prog_clk = 1'b0;
  logic         prog_rst_n;
  logic         start;
  logic [W-1:0] cfg_data;
  logic         cfg_valid;
  logic         cfg_ready;
  logic         ccff_head;
  logic         ccff_tail;
  logic         ccff_shift_en;
  logic         busy;
  logic         done;
  logic         error;
  logic         force_one;
  logic [N-1:0] chain;

  int total = 0;
  int bad   = 0;
  bit exp_q[$];

  typedef struct {
    logic [W-1:0] w0;
    logic [W-1:0] w1;
    int           stall;
    bit           fault;
    bit           start_mid;
    logic [N-1:0] exp_chain;
    bit           exp_err;
  } vec_t;

  vec_t vecs[4];

  ccff_loader #(.CHAIN_LEN(N), .DATA_W(W)) dut (
    .prog_clk      (prog_clk),
    .prog_rst_n    (prog_rst_n),
    .start         (start),
    .cfg_data      (cfg_data),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .ccff_head     (ccff_head),
    .ccff_tail     (ccff_tail),
    .ccff_shift_en (ccff_shift_en),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 prog_clk = ~prog_clk;

  always @(posedge prog_clk) if (ccff_shift_en) chain <= {chain[N-2:0], ccff_head};
  assign ccff_tail = force_one ? 1'b1 : chain[N-1];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, cfg_ready, 0);
    check({tag, "_head"}, ccff_head, 0);
    check({tag, "_shift_en"}, ccff_shift_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
  endtask

  // Runs one complete load from IDLE or DONE. Inputs change and outputs are
  // sampled on the falling edge.
  task automatic run_load(input vec_t v);
    logic [W-1:0] words[2];
    int  widx = 0, stall_left = v.stall, hs = 0;
    int  lshift = 0, vshift = 0, bubbles = 0;
    bit  in_ver = 0, ver_now, fault_done = 0, fin = 0;
    words[0] = v.w0;
    words[1] = v.w1;
    exp_q.delete();
    for (int i = 0; i < N; i++)
      exp_q.push_back(i < W ? words[0][W-1-i] : words[1][2*W-1-i]);

    @(negedge prog_clk);
    check("ready_before_start", cfg_ready, 0);
    start     = 1'b1;
    cfg_valid = 1'b1;       // valid together with start must not be captured
    cfg_data  = v.w0;
    @(negedge prog_clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("done_after_start", done, 0);
    check("error_after_start", error, 0);

    for (int cyc = 0; cyc < 300; cyc++) begin
      force_one = 1'b0;
      if (done) begin
        fin = 1;
        break;
      end
      ver_now = 0;
      if (!ccff_shift_en) check("head_zero_when_idle_shift", ccff_head, 0);
      if (ccff_shift_en && !in_ver) begin
        check($sformatf("load_head_bit%0d", lshift), ccff_head, exp_q.pop_front());
        lshift++;
        if (lshift == N) in_ver = 1;
      end else if (ccff_shift_en && in_ver) begin
        check("verify_head_eq_tail", ccff_head, ccff_tail);
        vshift++;
        ver_now = 1;
      end else if (!in_ver && lshift > 0) begin
        bubbles++;
      end
      if (v.fault && ver_now && !fault_done && chain[N-1] == 1'b0) begin
        force_one  = 1'b1;
        fault_done = 1;
      end
      start = (v.start_mid && lshift == 3 && !in_ver);
      if (widx == 1 && cfg_ready && stall_left > 0) begin
        cfg_valid = 1'b0;
        stall_left--;
      end else begin
        cfg_valid = 1'b1;
        cfg_data  = (widx < 2) ? words[widx] : 8'hFF;
        if (cfg_ready) begin
          hs++;
          widx++;
        end
      end
      @(negedge prog_clk);
    end

    check("finished_in_budget", fin, 1);
    check("done_final", done, 1);
    check("busy_final", busy, 0);
    check("error_final", error, v.exp_err);
    check("handshakes", hs, 2);
    check("load_shifts", lshift, N);
    check("verify_shifts", vshift, N);
    check("stall_bubbles", bubbles, v.stall);
    check("queue_drained", exp_q.size(), 0);
    if (v.fault) check("fault_injected", fault_done, 1);
    else         check("chain_contents", chain, v.exp_chain);
    cfg_valid = 1'b0;
    start     = 1'b0;
  endtask

  initial begin
    int seen;
    vecs[0] = '{w0: 8'hA5, w1: 8'hC0, stall: 0, fault: 0, start_mid: 0,
                exp_chain: 10'b1010010111, exp_err: 0};
    vecs[1] = '{w0: 8'hA5, w1: 8'hC0, stall: 3, fault: 0, start_mid: 0,
                exp_chain: 10'b1010010111, exp_err: 0};
    vecs[2] = '{w0: 8'hA5, w1: 8'hC0, stall: 0, fault: 1, start_mid: 0,
                exp_chain: 10'b0, exp_err: 1};
    vecs[3] = '{w0: 8'h3C, w1: 8'hFF, stall: 1, fault: 0, start_mid: 1,
                exp_chain: 10'b0011110011, exp_err: 0};

    prog_rst_n = 1'b0;
    start      = 1'b0;
    cfg_valid  = 1'b0;
    cfg_data   = '0;
    force_one  = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge prog_clk);
    prog_rst_n = 1'b1;

    // The first load starts from IDLE; each later load starts from DONE.
    foreach (vecs[k]) run_load(vecs[k]);

    // Reset in the middle of a load, after four bits have shifted.
    @(negedge prog_clk);
    start     = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = 8'hA5;
    @(negedge prog_clk);
    start = 1'b0;
    seen  = 0;
    for (int cyc = 0; cyc < 50 && seen < 4; cyc++) begin
      if (ccff_shift_en) seen++;
      if (seen < 4) @(negedge prog_clk);
    end
    check("midload_shifts_seen", seen, 4);
    @(posedge prog_clk);
    #2 prog_rst_n = 1'b0;
    #1 check_reset_outputs("midload_reset");
    cfg_valid = 1'b0;
    @(negedge prog_clk);
    prog_rst_n = 1'b1;
    run_load(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
